// File: rtl/cpu_pkg.sv
// cpu_pkg: instruction format and loader FSM encodings for the accumulator CPU
//   OPCODE_W/OPERAND_W describe the instruction word, HALT_WORD terminates a load,
//   ST_* fix the state encoding used by state_t.
package cpu_pkg;
  localparam int OPCODE_W = 5;
  localparam int OPERAND_W = 11;
  localparam logic [OPCODE_W+OPERAND_W-1:0] HALT_WORD = '0;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN = 2'd2;
  typedef enum logic [1:0] {IDLE = ST_IDLE, LOAD = ST_LOAD, RUN = ST_RUN} state_t;
endpackage

// File: rtl/program_memory_loader_if.sv
// program_memory_loader_if: byte load port plus instruction fetch port
//   load : i_LoadStart, i_Byte, i_ByteValid -> o_ByteReady, o_Loaded, o_WordCount, o_Overflow
//   fetch: i_Rd, i_Addr -> o_Data, o_DataValid
//   slave is the memory side, master is the boot/CPU side.
interface program_memory_loader_if #(parameter int NBITS_O = 11, NBITS_D = 16, NBITS_B = 8);
  logic               i_LoadStart;
  logic [NBITS_B-1:0] i_Byte;
  logic               i_ByteValid;
  logic               o_ByteReady;
  logic               o_Loaded;
  logic [NBITS_O:0]   o_WordCount;
  logic               o_Overflow;
  logic               i_Rd;
  logic [NBITS_O-1:0] i_Addr;
  logic [NBITS_D-1:0] o_Data;
  logic               o_DataValid;
  modport slave (
    input  i_LoadStart, i_Byte, i_ByteValid, i_Rd, i_Addr,
    output o_ByteReady, o_Loaded, o_WordCount, o_Overflow, o_Data, o_DataValid
  );
  modport master (
    output i_LoadStart, i_Byte, i_ByteValid, i_Rd, i_Addr,
    input  o_ByteReady, o_Loaded, o_WordCount, o_Overflow, o_Data, o_DataValid
  );
endinterface

// File: rtl/program_ram.sv
// program_ram: single-port synchronous RAM with registered read
//   i_We writes i_WData to i_Addr; i_Re loads o_RData with the word at i_Addr,
//   or zero (HALT) when i_Addr is beyond CELDAS. o_RData holds when i_Re is low.
module program_ram #(
  parameter int NBITS_O = 11,
  parameter int NBITS_D = 16,
  parameter int CELDAS = 2048
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_We,
  input  logic               i_Re,
  input  logic [NBITS_O-1:0] i_Addr,
  input  logic [NBITS_D-1:0] i_WData,
  output logic [NBITS_D-1:0] o_RData
);
  localparam int AW = $clog2(CELDAS);
  logic [NBITS_D-1:0] r_mem [CELDAS];
  logic w_inrange;
  assign w_inrange = {1'b0, i_Addr} < (NBITS_O+1)'(CELDAS);
  // No reset on the array so it maps onto block RAM and survives i_reset.
  always_ff @(posedge i_clk)
    if (i_We) r_mem[i_Addr[AW-1:0]] <= i_WData;
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) o_RData <= '0;
    else if (i_Re) o_RData <= w_inrange ? r_mem[i_Addr[AW-1:0]] : '0;
endmodule

// File: rtl/program_memory_loader.sv
// program_memory_loader: byte-serial program loader and fetch port for the accumulator CPU
//   i_clk, i_reset (async, active-low); bus carries the load and fetch signals.
//   Bytes arrive MSB first, are packed into NBITS_D-bit words and written from
//   address 0 until a HALT word or a full memory; fetches are served in RUN only.
module program_memory_loader
  import cpu_pkg::*;
#(
  parameter int NBITS_O = 11,
  parameter int NBITS_D = 16,
  parameter int NBITS_B = 8,
  parameter int CELDAS = 2048
) (
  input logic i_clk,
  input logic i_reset,
  program_memory_loader_if.slave bus
);
  localparam int BPW = NBITS_D / NBITS_B;
  localparam int BCW = $clog2(BPW + 1);
  state_t             r_state;
  logic [BCW-1:0]     r_bcnt;
  logic [NBITS_D-1:0] r_word;
  logic [NBITS_O:0]   r_wptr;
  logic               r_ready, r_loaded, r_ovf, r_dvalid;
  logic               w_xfer, w_last, w_we, w_re, w_halt, w_full;
  logic [NBITS_D-1:0] w_wdata;
  logic [NBITS_O-1:0] w_addr;
  // A restart pulse takes priority, so a byte offered alongside it is dropped.
  assign w_xfer  = bus.i_ByteValid && r_ready && !bus.i_LoadStart;
  assign w_last  = r_bcnt == BCW'(BPW - 1);
  assign w_we    = w_xfer && w_last;
  assign w_re    = r_state == RUN && bus.i_Rd;
  assign w_wdata = NBITS_D'({r_word, bus.i_Byte});
  assign w_halt  = w_wdata == NBITS_D'(HALT_WORD);
  assign w_full  = r_wptr == (NBITS_O+1)'(CELDAS - 1);
  // Writes only happen in LOAD and reads only in RUN, so one port suffices.
  assign w_addr  = w_we ? r_wptr[NBITS_O-1:0] : bus.i_Addr;
  program_ram #(.NBITS_O(NBITS_O), .NBITS_D(NBITS_D), .CELDAS(CELDAS)) u_ram (
    .i_clk(i_clk), .i_reset(i_reset), .i_We(w_we), .i_Re(w_re),
    .i_Addr(w_addr), .i_WData(w_wdata), .o_RData(bus.o_Data)
  );
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      r_state  <= IDLE;
      r_bcnt   <= '0;
      r_word   <= '0;
      r_wptr   <= '0;
      r_ready  <= 1'b0;
      r_loaded <= 1'b0;
      r_ovf    <= 1'b0;
      r_dvalid <= 1'b0;
    end else begin
      r_dvalid <= w_re;
      if (bus.i_LoadStart) begin
        r_state  <= LOAD;
        r_bcnt   <= '0;
        r_word   <= '0;
        r_wptr   <= '0;
        r_ready  <= 1'b1;
        r_loaded <= 1'b0;
        r_ovf    <= 1'b0;
      end else if (w_xfer) begin
        r_word <= w_wdata;
        r_bcnt <= w_last ? '0 : r_bcnt + 1'b1;
        if (w_last) begin
          r_wptr <= r_wptr + 1'b1;
          // HALT wins over full: a HALT in the last slot is not an overflow.
          if (w_halt || w_full) begin
            r_state  <= RUN;
            r_ready  <= 1'b0;
            r_loaded <= 1'b1;
            r_ovf    <= !w_halt;
          end
        end
      end
    end
  assign bus.o_ByteReady = r_ready;
  assign bus.o_Loaded    = r_loaded;
  assign bus.o_WordCount = r_wptr;
  assign bus.o_Overflow  = r_ovf;
  assign bus.o_DataValid = r_dvalid;
endmodule

// File: tb/tb_program_memory_loader.sv
// tb_program_memory_loader: directed table-driven bench for program_memory_loader (CELDAS = 4)
module tb_program_memory_loader;
  logic clk = 1'b0;
  logic rst_n;
  int vec_n = 0;
  int err_n = 0;
  always #5 clk = ~clk;
  program_memory_loader_if #(.NBITS_O(11), .NBITS_D(16), .NBITS_B(8)) bus ();
  program_memory_loader #(.NBITS_O(11), .NBITS_D(16), .NBITS_B(8), .CELDAS(4)) dut (
    .i_clk(clk), .i_reset(rst_n), .bus(bus)
  );
  typedef struct {
    logic        rd;
    logic [10:0] addr;
    logic        exp_v;
    logic [15:0] exp_d;
  } fvec_t;
  fvec_t fv[12];
  logic [7:0] prog[8];
  logic [15:0] prog_words[4];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input bit gap);
    bus.i_Byte = b;
    bus.i_ByteValid = 1'b1;
    tick();
    bus.i_ByteValid = 1'b0;
    if (gap) repeat ($urandom_range(0, 2)) tick();
  endtask
  task automatic start(input bit with_byte, input logic [7:0] b);
    bus.i_LoadStart = 1'b1;
    bus.i_ByteValid = with_byte;
    bus.i_Byte = b;
    tick();
    bus.i_LoadStart = 1'b0;
    bus.i_ByteValid = 1'b0;
  endtask
  task automatic fetch(input logic [10:0] a, input logic [15:0] exp, input string name);
    bus.i_Rd = 1'b1;
    bus.i_Addr = a;
    tick();
    bus.i_Rd = 1'b0;
    check({name, "_valid"}, 32'(bus.o_DataValid), 32'd1);
    check({name, "_data"}, 32'(bus.o_Data), 32'(exp));
  endtask
  initial begin
    prog = '{8'h10, 8'h01, 8'h28, 8'h02, 8'h08, 8'h07, 8'h00, 8'h00};
    prog_words = '{16'h1001, 16'h2802, 16'h0807, 16'h0000};
    fv[0]  = '{1'b1, 11'd0,    1'b1, 16'h1001};
    fv[1]  = '{1'b1, 11'd1,    1'b1, 16'h2802};
    fv[2]  = '{1'b1, 11'd2,    1'b1, 16'h0807};
    fv[3]  = '{1'b1, 11'd3,    1'b1, 16'h0000};
    fv[4]  = '{1'b1, 11'd1,    1'b1, 16'h2802};
    fv[5]  = '{1'b0, 11'd0,    1'b0, 16'h2802};
    fv[6]  = '{1'b1, 11'd4,    1'b1, 16'h0000};
    fv[7]  = '{1'b0, 11'd3,    1'b0, 16'h0000};
    fv[8]  = '{1'b1, 11'd2,    1'b1, 16'h0807};
    fv[9]  = '{1'b1, 11'd2047, 1'b1, 16'h0000};
    fv[10] = '{1'b1, 11'd0,    1'b1, 16'h1001};
    fv[11] = '{1'b0, 11'd3,    1'b0, 16'h1001};
    rst_n = 1'b1;
    bus.i_LoadStart = 1'b0;
    bus.i_Byte = '0;
    bus.i_ByteValid = 1'b0;
    bus.i_Rd = 1'b0;
    bus.i_Addr = '0;
    #12 rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(bus.o_DataValid), 0);
    check("rst_ready", 32'(bus.o_ByteReady), 0);
    check("rst_loaded", 32'(bus.o_Loaded), 0);
    check("rst_count", 32'(bus.o_WordCount), 0);
    check("rst_ovf", 32'(bus.o_Overflow), 0);
    check("rst_data", 32'(bus.o_Data), 0);
    tick();
    rst_n = 1'b1;
    tick();
    bus.i_Rd = 1'b1;
    bus.i_Addr = '0;
    tick();
    check("idle_fetch_valid", 32'(bus.o_DataValid), 0);
    tick();
    check("idle_fetch_valid2", 32'(bus.o_DataValid), 0);
    bus.i_Rd = 1'b0;
    start(1'b0, 8'h00);
    check("load_ready", 32'(bus.o_ByteReady), 1);
    check("load_loaded", 32'(bus.o_Loaded), 0);
    for (int i = 0; i < 8; i++) begin
      send(prog[i], 1'b0);
      if (i == 5) check("mid_count", 32'(bus.o_WordCount), 3);
    end
    check("norm_count", 32'(bus.o_WordCount), 4);
    check("norm_loaded", 32'(bus.o_Loaded), 1);
    check("norm_ready", 32'(bus.o_ByteReady), 0);
    check("norm_ovf", 32'(bus.o_Overflow), 0);
    for (int i = 0; i < 12; i++) begin
      bus.i_Rd = fv[i].rd;
      bus.i_Addr = fv[i].addr;
      tick();
      check($sformatf("fv%0d_valid", i), 32'(bus.o_DataValid), 32'(fv[i].exp_v));
      check($sformatf("fv%0d_data", i), 32'(bus.o_Data), 32'(fv[i].exp_d));
    end
    bus.i_Rd = 1'b0;
    start(1'b0, 8'h00);
    check("thr_count0", 32'(bus.o_WordCount), 0);
    for (int i = 0; i < 8; i++) send(prog[i], 1'b1);
    check("thr_count", 32'(bus.o_WordCount), 4);
    check("thr_loaded", 32'(bus.o_Loaded), 1);
    for (int i = 0; i < 4; i++) fetch(11'(i), prog_words[i], $sformatf("thr%0d", i));
    start(1'b1, 8'h55);
    send(8'hAB, 1'b0);
    start(1'b1, 8'hCD);
    check("rs_count0", 32'(bus.o_WordCount), 0);
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    check("rs_count", 32'(bus.o_WordCount), 2);
    check("rs_loaded", 32'(bus.o_Loaded), 1);
    fetch(11'd0, 16'h1234, "rs0");
    fetch(11'd1, 16'h0000, "rs1");
    fetch(11'd2, 16'h0807, "rs2");
    start(1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      send(8'(8'h11 * (i + 1)), 1'b0);
      send(8'(8'h11 * (i + 1)), 1'b0);
      if (i == 3) begin
        check("ovf_flag", 32'(bus.o_Overflow), 1);
        check("ovf_loaded", 32'(bus.o_Loaded), 1);
        check("ovf_ready", 32'(bus.o_ByteReady), 0);
      end
    end
    check("ovf_count", 32'(bus.o_WordCount), 4);
    fetch(11'd3, 16'h4444, "ovf3");
    fetch(11'd0, 16'h1111, "ovf0");
    check("ovf_flag_sticky", 32'(bus.o_Overflow), 1);
    start(1'b0, 8'h00);
    check("ovf_cleared", 32'(bus.o_Overflow), 0);
    send(8'h77, 1'b0);
    send(8'h88, 1'b0);
    send(8'hAB, 1'b0);
    check("abort_count_pre", 32'(bus.o_WordCount), 1);
    #3 rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(bus.o_ByteReady), 0);
    check("abort_count", 32'(bus.o_WordCount), 0);
    check("abort_data", 32'(bus.o_Data), 0);
    tick();
    rst_n = 1'b1;
    tick();
    send(8'h99, 1'b0);
    check("abort_idle_count", 32'(bus.o_WordCount), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
    $finish;
  end
endmodule

// File: doc/program_memory_loader.md
# program_memory_loader

Parametrised program memory for the accumulator CPU, with a byte-serial load port replacing the hard-coded reset image. The boot/UART side streams instruction bytes in; the block assembles them into NBITS_D-bit words, writes them sequentially from address 0, and stops on a halt word or when memory is full. Once loaded, it serves registered instruction fetches to the CPU's program counter.

## Interface
- NBITS_O, 11: fetch address width.
- NBITS_D, 16: instruction width; must be an integer multiple of NBITS_B.
- NBITS_B, 8: load-port byte width.
- CELDAS, 2048: memory depth in words; CELDAS ≤ 2^NBITS_O.
- i_clk  in  1  single clock; all logic on posedge.
- i_reset  in  1  asynchronous, active-low reset.
- i_LoadStart  in  1  one-cycle pulse; starts a new load from address 0.
- i_Byte  in  NBITS_B  load byte, most-significant byte of each word first.
- i_ByteValid  in  1  i_Byte is valid this cycle.
- o_ByteReady  out  1  block accepts a byte this cycle; high only in LOAD.
- o_Loaded  out  1  program loaded and fetch enabled; high only in RUN.
- o_WordCount  out  NBITS_O+1  number of words written by the current or last load.
- o_Overflow  out  1  sticky; memory filled before a halt word arrived.
- i_Rd  in  1  fetch enable.
- i_Addr  in  NBITS_O  fetch address.
- o_Data  out  NBITS_D  fetched instruction, registered.
- o_DataValid  out  1  o_Data holds a fetch result issued the previous cycle.

## Operation
- FSM states: IDLE, LOAD, RUN. Reset enters IDLE.
- IDLE: on i_LoadStart go to LOAD; clear the byte counter, write pointer, o_WordCount and o_Overflow.
- LOAD: a byte transfers when i_ByteValid && o_ByteReady.
  - Bytes shift into the word register, MSB first.
  - The transfer that completes a word (byte NBITS_D/NBITS_B) writes memory[wptr] in the same cycle, then wptr and o_WordCount each increment by 1.
  - If the completed word is all zeros (HALT, opcode 00000), it is written, then the FSM goes to RUN.
  - If wptr reaches CELDAS after a write and that word is not HALT: set o_Overflow, go to RUN.
  - i_LoadStart during LOAD restarts the load: counters clear and the partial word is discarded. Memory is not cleared.
- RUN: fetch is enabled.
  - On i_Rd: o_Data <= memory[i_Addr] if i_Addr < CELDAS, else all zeros (HALT). o_DataValid <= 1.
  - With i_Rd low: o_Data holds its value and o_DataValid <= 0.
  - i_LoadStart in RUN returns to LOAD, with the same clearing as IDLE.
- Fetches outside RUN are ignored: o_Data holds, o_DataValid = 0.
- Memory array has no reset. Contents survive i_reset; locations never written read X in simulation.

## Timing
- Reset values: o_Data = 0, o_DataValid = 0, o_ByteReady = 0, o_Loaded = 0, o_WordCount = 0, o_Overflow = 0, state = IDLE, byte counter = 0, wptr = 0.
- Asserting reset mid-load aborts the load. The partially written memory keeps its contents.
- Fetch latency is 1 cycle: address sampled at edge N, data valid after edge N, o_DataValid high for that cycle. Back-to-back fetches give one result per cycle.
- Load throughput is one byte per cycle. o_ByteReady is a registered function of state; it drops the cycle after the terminating write.
- o_Loaded rises the cycle after the final word's write. The first valid fetch can be issued that same cycle.
- Simultaneous i_LoadStart and i_ByteValid in IDLE/RUN: only the start is taken; the byte is not consumed (o_ByteReady was low).
- Simultaneous i_LoadStart and a byte transfer in LOAD: the restart wins and the byte is dropped.

## Structure
- Shared package cpu_pkg holds:
  - instruction format constants: OPCODE_W = 5, OPERAND_W = 11, HALT word = 0;
  - FSM state encoding localparams for IDLE/LOAD/RUN.
- Natural sub-module: program_ram. It is a single-port synchronous RAM (write-enable, address mux between wptr and i_Addr, registered read) so synthesis infers BRAM. The FSM and byte assembler stay in the top.

## Test plan
- Reset and idle: reset low mid-cycle → all outputs 0 immediately. i_Rd with i_Addr = 0 in IDLE → o_DataValid stays 0.
- Normal load: start, then bytes 10 01 28 02 08 07 00 00 → o_WordCount = 4, o_Loaded rises. Fetches of 0..3 → 0x1001, 0x2802, 0x0807, 0x0000, each with 1-cycle latency.
- Throttled source: same stream with i_ByteValid gapped randomly → identical memory contents and count.
- Overflow: CELDAS = 4; stream 5 non-zero words → only 4 written, o_Overflow = 1, o_Loaded = 1, fetch of address 3 returns word 4, fifth word ignored.
- Restart mid-word: send 0xAB, pulse i_LoadStart, then send a full program → address 0 holds the new first word, not 0xAB--.
- Out-of-range and held fetch: i_Addr = CELDAS → o_Data = 0. i_Rd low → o_Data holds the previous value and o_DataValid = 0.
